// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_RESET_PC   = 0;
    localparam int FIFO_DEPTH     = 2;

    // Occupancy after this edge must leave room for the request issued now.
    function automatic logic can_issue(
        input logic [1:0] count,
        input logic       inflight,
        input logic       pop
    );
        logic [2:0] occ;
        occ = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        return occ < 3'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry shift FIFO holding {pc, inst} pairs for the fetch stage.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_WIDTH + DEF_INST_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [1:0]       count_o,
    output logic [WIDTH-1:0] head_o
);

    logic [WIDTH-1:0] e0_q, e0_d;
    logic [WIDTH-1:0] e1_q, e1_d;
    logic [1:0]       count_q, count_d;
    logic             do_pop;

    assign do_pop = pop_i && (count_q != 2'd0);

    always_comb begin
        e0_d    = e0_q;
        e1_d    = e1_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_i, do_pop})
                2'b10: begin
                    if (count_q == 2'd0) e0_d = data_i;
                    else                 e1_d = data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    e0_d    = e1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Entry 0 leaves; the new item lands behind whatever remains.
                    if (count_q == 2'd2) begin
                        e0_d = e1_q;
                        e1_d = data_i;
                    end else begin
                        e0_d = data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_q    <= '0;
            e1_q    <= '0;
            count_q <= 2'd0;
        end else begin
            e0_q    <= e0_d;
            e1_q    <= e1_d;
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = (count_q != 2'd0) ? e0_q : '0;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC/issue control in front of a synchronous instmem,
// feeding {pc, inst} pairs to decode through a 2-entry buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEF_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] AR,
    input  logic [INST_WIDTH-1:0] Q,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  halt_i
);

    localparam int EW = ADDR_WIDTH + INST_WIDTH;

    logic [ADDR_WIDTH-1:0] ar_q, ar_d;
    logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            fifo_count;
    logic [EW-1:0]         head;
    logic                  pop;
    logic                  push;
    logic                  issue;

    assign valid_o = (fifo_count != 2'd0);
    assign pop     = valid_o && ready_i;
    // A response arriving on a redirect edge belongs to the old path.
    assign push    = inflight_q && !redirect_i;
    assign issue   = !halt_i && !redirect_i
                     && can_issue(fifo_count, inflight_q, pop);

    always_comb begin
        ar_d          = ar_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        if (redirect_i) begin
            ar_d = redirect_pc_i;
        end else if (issue) begin
            inflight_d    = 1'b1;
            inflight_pc_d = ar_q;
            ar_d          = ar_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            ar_q          <= ar_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .WIDTH(EW)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .data_i ({inflight_pc_q, Q}),
        .pop_i  (pop),
        .flush_i(redirect_i),
        .count_o(fifo_count),
        .head_o (head)
    );

    assign AR             = ar_q;
    assign {pc_o, inst_o} = head;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int AW = 8;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] AR;
    logic [IW-1:0] Q = '0;
    logic [IW-1:0] inst_o;
    logic [AW-1:0] pc_o;
    logic          valid_o;
    logic          ready = 1'b1;
    logic          redir = 1'b0;
    logic [AW-1:0] rpc = '0;
    logic          halt = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending pcs, outstanding request, next pc.
    int mq[$];
    int m_ar;
    int m_infl;
    int m_ipc;

    typedef struct {
        bit ready;
        bit redir;
        int rpc;
        bit halt;
        bit ev;
        int epc;
        int ear;
    } vec_t;

    vec_t tbl[18];

    always #5 clk = ~clk;

    // instmem stand-in preloaded with mem[a] = a.
    always @(posedge clk) Q <= IW'(AR);

    fetch_unit #(
        .ADDR_WIDTH(AW),
        .INST_WIDTH(IW),
        .RESET_PC  (8'd0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .AR           (AR),
        .Q            (Q),
        .inst_o       (inst_o),
        .pc_o         (pc_o),
        .valid_o      (valid_o),
        .ready_i      (ready),
        .redirect_i   (redir),
        .redirect_pc_i(rpc),
        .halt_i       (halt)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_infl = 0;
        m_ipc  = 0;
        m_ar   = 0;
    endtask

    task automatic model_edge();
        int pop;
        int issue;
        pop = (mq.size() != 0 && ready) ? 1 : 0;
        if (redir) begin
            mq.delete();
            m_infl = 0;
            m_ar   = int'(rpc);
        end else begin
            issue = (!halt && (mq.size() + m_infl - pop) < 2) ? 1 : 0;
            if (pop != 0) void'(mq.pop_front());
            if (m_infl != 0) mq.push_back(m_ipc);
            if (issue != 0) begin
                m_infl = 1;
                m_ipc  = m_ar;
                m_ar   = (m_ar + 1) % (1 << AW);
            end else begin
                m_infl = 0;
            end
        end
    endtask

    task automatic model_compare();
        chk("valid", 64'(valid_o), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("pc", 64'(pc_o), 64'(mq[0]));
            chk("inst", 64'(inst_o), 64'(mq[0]));
        end else begin
            chk("pc_empty", 64'(pc_o), 64'd0);
            chk("inst_empty", 64'(inst_o), 64'd0);
        end
        chk("AR", 64'(AR), 64'(m_ar));
        chk("count", 64'(dut.fifo_count), 64'(mq.size()));
    endtask

    // Inputs are already set; advance one edge and check at the falling edge.
    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        model_compare();
    endtask

    initial begin
        int exp_wrap[4];
        exp_wrap = '{254, 255, 0, 1};

        tbl[0]  = '{1, 0, 0, 0, 0, 0, 1};
        tbl[1]  = '{1, 0, 0, 0, 1, 0, 2};
        tbl[2]  = '{1, 0, 0, 0, 1, 1, 3};
        tbl[3]  = '{1, 0, 0, 0, 1, 2, 4};
        tbl[4]  = '{1, 0, 0, 0, 1, 3, 5};
        tbl[5]  = '{1, 0, 0, 0, 1, 4, 6};
        tbl[6]  = '{0, 0, 0, 0, 1, 4, 6};
        tbl[7]  = '{0, 0, 0, 0, 1, 4, 6};
        tbl[8]  = '{0, 0, 0, 0, 1, 4, 6};
        tbl[9]  = '{0, 0, 0, 0, 1, 4, 6};
        tbl[10] = '{0, 0, 0, 0, 1, 4, 6};
        tbl[11] = '{1, 0, 0, 0, 1, 5, 7};
        tbl[12] = '{1, 0, 0, 0, 1, 6, 8};
        tbl[13] = '{1, 0, 0, 0, 1, 7, 9};
        tbl[14] = '{1, 1, 32, 0, 0, 0, 32};
        tbl[15] = '{1, 0, 0, 0, 0, 0, 33};
        tbl[16] = '{1, 0, 0, 0, 1, 32, 34};
        tbl[17] = '{1, 0, 0, 0, 1, 33, 35};

        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_AR", 64'(AR), 64'd0);
        chk("rst_pc", 64'(pc_o), 64'd0);
        rst = 1'b0;

        // Stream, backpressure, redirect with ready high
        for (int i = 0; i < 18; i++) begin
            ready = tbl[i].ready;
            redir = tbl[i].redir;
            rpc   = AW'(tbl[i].rpc);
            halt  = tbl[i].halt;
            step();
            chk("tbl_valid", 64'(valid_o), 64'(tbl[i].ev));
            if (tbl[i].ev) chk("tbl_pc", 64'(pc_o), 64'(tbl[i].epc));
            chk("tbl_AR", 64'(AR), 64'(tbl[i].ear));
        end
        redir = 1'b0;

        // Redirect while stalled: head discarded, same latency
        ready = 1'b0;
        repeat (3) step();
        redir = 1'b1;
        rpc   = 8'h40;
        step();
        chk("rdn_valid0", 64'(valid_o), 64'd0);
        redir = 1'b0;
        ready = 1'b1;
        step();
        chk("rdn_valid1", 64'(valid_o), 64'd0);
        step();
        chk("rdn_pc", 64'(pc_o), 64'h40);

        // Wrap-around at the top of the address space
        redir = 1'b1;
        rpc   = 8'd254;
        step();
        redir = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wrap_valid", 64'(valid_o), 64'd1);
            chk("wrap_pc", 64'(pc_o), 64'(exp_wrap[i]));
        end

        // Halt for 4 cycles with ready high
        halt = 1'b1;
        step();
        step();
        chk("halt_drained", 64'(valid_o), 64'd0);
        step();
        step();
        halt = 1'b0;
        repeat (4) step();

        // Asynchronous reset mid-cycle with the buffer full
        ready = 1'b0;
        repeat (3) step();
        chk("pre_rst_count", 64'(dut.fifo_count), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(valid_o), 64'd0);
        chk("arst_AR", 64'(AR), 64'd0);
        model_reset();
        @(negedge clk);
        rst   = 1'b0;
        ready = 1'b1;
        step();
        chk("restart_valid0", 64'(valid_o), 64'd0);
        step();
        chk("restart_pc", 64'(pc_o), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(0, 9) < 7);
            redir = ($urandom_range(0, 19) == 0);
            rpc   = AW'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
